cmp_arb: RTL and testbench

//  Arbiter sharing a single cmp_gen comparator between two requesters: req0 is the branch unit, req1 is the ALU SLT/SLTU path.
//  - Grants one request per cycle and latches its operands into a stage register that drives cmp_gen.
//  - Reduces the cmp_gen flags to a 1-bit result using a RISC-V funct3 code.
//  - Holds each result in a per-requester response register until it is accepted.

---
 rtl/cmp_arb_if.sv | 63 ++++++
 rtl/cmp_arb.sv | 166 ++++++++++++++++
 tb/tb_cmp_arb.sv | 553 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_arb_if.sv
// Request/response bundle between two requesters, the shared-comparator
// arbiter and the cmp_gen comparator flags.
//
// Handshake: a request transfers on the rising edge where reqN_vld and reqN_rdy
// are both high. A response transfers on the edge where rspN_vld and rspN_rdy
// are both high. vld must not depend on rdy. rdy is only asserted while the
// matching vld is high. rspN_vld and rspN_res stay stable until the response
// transfers.
interface cmp_arb_if #(
   parameter int DATA_W = 32
);

   // Requester 0 (branch unit)
   logic              req0_vld_w_i_h;
   logic              req0_rdy_w_o_h;
   logic [DATA_W-1:0] req0_a_w_i;
   logic [DATA_W-1:0] req0_b_w_i;
   logic [2:0]        req0_op_w_i;
   logic              rsp0_vld_w_o_h;
   logic              rsp0_rdy_w_i_h;
   logic              rsp0_res_w_o_h;

   // Requester 1 (ALU SLT/SLTU path)
   logic              req1_vld_w_i_h;
   logic              req1_rdy_w_o_h;
   logic [DATA_W-1:0] req1_a_w_i;
   logic [DATA_W-1:0] req1_b_w_i;
   logic [2:0]        req1_op_w_i;
   logic              rsp1_vld_w_o_h;
   logic              rsp1_rdy_w_i_h;
   logic              rsp1_res_w_o_h;

   // Shared comparator operands and its flags
   logic [DATA_W-1:0] cmp_a_w_o;
   logic [DATA_W-1:0] cmp_b_w_o;
   logic              eq_w_i_h;
   logic              ltu_w_i_h;
   logic              gteu_w_i_h;
   logic              lts_w_i_h;
   logic              gtes_w_i_h;

   // Arbiter view: takes requests and comparator flags, produces grants,
   // responses and comparator operands.
   modport slave (
      input  req0_vld_w_i_h, req0_a_w_i, req0_b_w_i, req0_op_w_i, rsp0_rdy_w_i_h,
      input  req1_vld_w_i_h, req1_a_w_i, req1_b_w_i, req1_op_w_i, rsp1_rdy_w_i_h,
      input  eq_w_i_h, ltu_w_i_h, gteu_w_i_h, lts_w_i_h, gtes_w_i_h,
      output req0_rdy_w_o_h, rsp0_vld_w_o_h, rsp0_res_w_o_h,
      output req1_rdy_w_o_h, rsp1_vld_w_o_h, rsp1_res_w_o_h,
      output cmp_a_w_o, cmp_b_w_o
   );

   // Environment view: requesters plus the comparator.
   modport master (
      output req0_vld_w_i_h, req0_a_w_i, req0_b_w_i, req0_op_w_i, rsp0_rdy_w_i_h,
      output req1_vld_w_i_h, req1_a_w_i, req1_b_w_i, req1_op_w_i, rsp1_rdy_w_i_h,
      output eq_w_i_h, ltu_w_i_h, gteu_w_i_h, lts_w_i_h, gtes_w_i_h,
      input  req0_rdy_w_o_h, rsp0_vld_w_o_h, rsp0_res_w_o_h,
      input  req1_rdy_w_o_h, rsp1_vld_w_o_h, rsp1_res_w_o_h,
      input  cmp_a_w_o, cmp_b_w_o
   );

endinterface

// File: rtl/cmp_arb.sv
// cmp_arb: shares one cmp_gen comparator between the branch unit (req0) and the
// ALU SLT/SLTU path (req1).
// A granted request is latched into a one-deep stage that drives the
// comparator. On the following edge the flags are reduced by funct3 and the
// result is parked in that requester's response register until it is taken.
// Each requester has at most one operation in flight (stage or response).
module cmp_arb #(
   parameter int DATA_W = 32,
   parameter bit RR_EN  = 1'b1
) (
   input  logic       clk_w_i,
   input  logic       rst_w_i_h,
   cmp_arb_if.slave   bus
);

   // Requester inputs gathered into indexable form
   logic [1:0]        vld_w;
   logic [1:0]        rsp_rdy_w;
   logic [DATA_W-1:0] req_a_w [2];
   logic [DATA_W-1:0] req_b_w [2];
   logic [2:0]        req_op_w [2];

   // Arbitration
   logic [1:0]        elig_w;
   logic [1:0]        gnt_w;
   logic              xfer_w;
   logic              gnt_id_w;

   // Stage register feeding cmp_gen
   logic              stg_vld_q, stg_vld_d;
   logic              stg_id_q,  stg_id_d;
   logic [2:0]        stg_op_q,  stg_op_d;
   logic [DATA_W-1:0] cmp_a_q,   cmp_a_d;
   logic [DATA_W-1:0] cmp_b_q,   cmp_b_d;

   // Round-robin memory: id of the requester that transferred last.
   // Reset value 1 makes req0 the preferred requester after reset.
   logic              last_q, last_d;

   // Per-requester response registers
   logic [1:0]        rsp_vld_q, rsp_vld_d;
   logic [1:0]        rsp_res_q, rsp_res_d;

   // Reduced comparator result for the staged op
   logic              res_w;

   assign vld_w       = {bus.req1_vld_w_i_h, bus.req0_vld_w_i_h};
   assign rsp_rdy_w   = {bus.rsp1_rdy_w_i_h, bus.rsp0_rdy_w_i_h};
   assign req_a_w[0]  = bus.req0_a_w_i;
   assign req_a_w[1]  = bus.req1_a_w_i;
   assign req_b_w[0]  = bus.req0_b_w_i;
   assign req_b_w[1]  = bus.req1_b_w_i;
   assign req_op_w[0] = bus.req0_op_w_i;
   assign req_op_w[1] = bus.req1_op_w_i;

   // A requester may only be granted when nothing of its own is staged or
   // waiting in its response register. A response drained this cycle still
   // blocks its requester until the next cycle (no bypass).
   always_comb begin
      elig_w    = 2'b00;
      elig_w[0] = vld_w[0] & ~rsp_vld_q[0] & ~(stg_vld_q & ~stg_id_q);
      elig_w[1] = vld_w[1] & ~rsp_vld_q[1] & ~(stg_vld_q &  stg_id_q);
   end

   // One-hot grant: single eligible wins outright; on a tie either the
   // requester not served last (round-robin) or req0 (fixed priority).
   // Held at zero during reset so no rdy is ever seen while in reset.
   always_comb begin
      gnt_w = 2'b00;
      if (!rst_w_i_h) begin
         case (elig_w)
            2'b01:   gnt_w = 2'b01;
            2'b10:   gnt_w = 2'b10;
            2'b11: begin
               if (RR_EN) begin
                  gnt_w = last_q ? 2'b01 : 2'b10;
               end else begin
                  gnt_w = 2'b01;
               end
            end
            default: gnt_w = 2'b00;
         endcase
      end
   end

   assign xfer_w   = |gnt_w;
   assign gnt_id_w = gnt_w[1];

   // Reduce the cmp_gen flags to a single result using funct3.
   // 010/011 are the SLT/SLTU encodings and map onto signed/unsigned less-than.
   always_comb begin
      res_w = 1'b0;
      case (stg_op_q)
         3'b000:  res_w = bus.eq_w_i_h;
         3'b001:  res_w = ~bus.eq_w_i_h;
         3'b010:  res_w = bus.lts_w_i_h;
         3'b011:  res_w = bus.ltu_w_i_h;
         3'b100:  res_w = bus.lts_w_i_h;
         3'b101:  res_w = bus.gtes_w_i_h;
         3'b110:  res_w = bus.ltu_w_i_h;
         3'b111:  res_w = bus.gteu_w_i_h;
         default: res_w = 1'b0;
      endcase
   end

   // Next state: stage loads on a transfer (operands hold otherwise), the
   // staged op retires into its response register, responses clear on accept.
   always_comb begin
      stg_vld_d = xfer_w;
      stg_id_d  = stg_id_q;
      stg_op_d  = stg_op_q;
      cmp_a_d   = cmp_a_q;
      cmp_b_d   = cmp_b_q;
      last_d    = last_q;
      rsp_vld_d = rsp_vld_q & ~rsp_rdy_w;
      rsp_res_d = rsp_res_q;

      if (xfer_w) begin
         stg_id_d = gnt_id_w;
         stg_op_d = req_op_w[gnt_id_w];
         cmp_a_d  = req_a_w[gnt_id_w];
         cmp_b_d  = req_b_w[gnt_id_w];
         last_d   = gnt_id_w;
      end

      // The eligibility rule guarantees the target response slot is empty,
      // so this never collides with a drain of the same requester.
      if (stg_vld_q) begin
         rsp_vld_d[stg_id_q] = 1'b1;
         rsp_res_d[stg_id_q] = res_w;
      end
   end

   // State registers; reset drops any staged op and pending responses.
   always_ff @(posedge clk_w_i or posedge rst_w_i_h) begin
      if (rst_w_i_h) begin
         stg_vld_q <= 1'b0;
         stg_id_q  <= 1'b0;
         stg_op_q  <= 3'b000;
         cmp_a_q   <= '0;
         cmp_b_q   <= '0;
         last_q    <= 1'b1;
         rsp_vld_q <= 2'b00;
         rsp_res_q <= 2'b00;
      end else begin
         stg_vld_q <= stg_vld_d;
         stg_id_q  <= stg_id_d;
         stg_op_q  <= stg_op_d;
         cmp_a_q   <= cmp_a_d;
         cmp_b_q   <= cmp_b_d;
         last_q    <= last_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_res_q <= rsp_res_d;
      end
   end

   assign bus.req0_rdy_w_o_h = gnt_w[0];
   assign bus.req1_rdy_w_o_h = gnt_w[1];
   assign bus.rsp0_vld_w_o_h = rsp_vld_q[0];
   assign bus.rsp1_vld_w_o_h = rsp_vld_q[1];
   assign bus.rsp0_res_w_o_h = rsp_res_q[0];
   assign bus.rsp1_res_w_o_h = rsp_res_q[1];
   assign bus.cmp_a_w_o      = cmp_a_q;
   assign bus.cmp_b_w_o      = cmp_b_q;

endmodule

// File: tb/tb_cmp_arb.sv
// Bench for cmp_arb: clock/reset, a combinational cmp_gen stand-in, requester
// driver tasks, a per-cycle scoreboard built from the arbitration rules and a
// funct3 reference, then one task per scenario.
module tb_cmp_arb;

   localparam int DATA_W = 32;
   localparam bit RR_EN  = 1'b1;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   cmp_arb_if #(.DATA_W(DATA_W)) bus ();

   cmp_arb #(.DATA_W(DATA_W), .RR_EN(RR_EN)) dut (
      .clk_w_i   (clk),
      .rst_w_i_h (rst),
      .bus       (bus)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- cmp_gen stand-in ----------------
   always_comb begin
      bus.eq_w_i_h   = (bus.cmp_a_w_o == bus.cmp_b_w_o);
      bus.ltu_w_i_h  = (bus.cmp_a_w_o <  bus.cmp_b_w_o);
      bus.gteu_w_i_h = (bus.cmp_a_w_o >= bus.cmp_b_w_o);
      bus.lts_w_i_h  = ($signed(bus.cmp_a_w_o) <  $signed(bus.cmp_b_w_o));
      bus.gtes_w_i_h = ($signed(bus.cmp_a_w_o) >= $signed(bus.cmp_b_w_o));
   end

   // ---------------- reference result ----------------
   function automatic logic ref_res(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                    input logic [2:0] op);
      case (op)
         3'b000:         return a == b;
         3'b001:         return a != b;
         3'b010, 3'b100: return $signed(a) < $signed(b);
         3'b011, 3'b110: return a < b;
         3'b101:         return $signed(a) >= $signed(b);
         default:        return a >= b;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_req(input int id, input logic v, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input logic [2:0] op);
      if (id == 0) begin
         bus.req0_vld_w_i_h = v; bus.req0_a_w_i = a; bus.req0_b_w_i = b; bus.req0_op_w_i = op;
      end else begin
         bus.req1_vld_w_i_h = v; bus.req1_a_w_i = a; bus.req1_b_w_i = b; bus.req1_op_w_i = op;
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_opnd(input logic [DATA_W-1:0] other);
      logic [DATA_W-1:0] v;
      case ($urandom_range(0, 4))
         0: v = DATA_W'($urandom_range(0, 3));
         1: begin
            case ($urandom_range(0, 3))
               0:       v = {1'b1, {(DATA_W-1){1'b0}}};
               1:       v = {1'b0, {(DATA_W-1){1'b1}}};
               2:       v = '1;
               default: v = '0;
            endcase
         end
         2:       v = other;
         default: v = DATA_W'($urandom);
      endcase
      return v;
   endfunction

   task automatic random_req(input int id, input logic v);
      logic [DATA_W-1:0] a;
      a = rand_opnd(DATA_W'($urandom));
      set_req(id, v, a, rand_opnd(a), 3'($urandom_range(0, 7)));
   endtask

   function automatic logic get_rdy(input int id);
      return (id == 0) ? bus.req0_rdy_w_o_h : bus.req1_rdy_w_o_h;
   endfunction

   function automatic logic get_rsp_vld(input int id);
      return (id == 0) ? bus.rsp0_vld_w_o_h : bus.rsp1_vld_w_o_h;
   endfunction

   function automatic logic get_rsp_res(input int id);
      return (id == 0) ? bus.rsp0_res_w_o_h : bus.rsp1_res_w_o_h;
   endfunction

   // Called just after a rising edge; returns just after the transfer edge
   // with vld dropped.
   task automatic drive_req(input int id, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input logic [2:0] op, output bit ok);
      ok = 1'b0;
      set_req(id, 1'b1, a, b, op);
      for (int k = 0; k < 50 && !ok; k++) begin
         #1;
         if (get_rdy(id) === 1'b1) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      set_req(id, 1'b0, a, b, op);
      if (!ok) begin
         errors++;
         checks++;
         $display("FAIL drive_req_timeout: id=%0d no grant within 50 cycles", id);
      end
   endtask

   // Waits for a response (rsp_rdy assumed high) and steps past its drain edge.
   task automatic wait_rsp(input int id, output logic res, output bit ok);
      ok  = 1'b0;
      res = 1'bx;
      for (int k = 0; k < 20 && !ok; k++) begin
         if (get_rsp_vld(id) === 1'b1) begin
            res = get_rsp_res(id);
            ok  = 1'b1;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      set_req(0, 1'b0, '0, '0, 3'b000);
      set_req(1, 1'b0, '0, '0, 3'b000);
      bus.rsp0_rdy_w_i_h = 1'b1;
      bus.rsp1_rdy_w_i_h = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [0:0] exp_q0[$];
   logic [0:0] exp_q1[$];
   bit         busy [2];
   int         t_n [2];
   bit         last_gnt = 1'b1;
   int         xfer_cnt [2];
   int         drain_cnt [2];

   initial begin : scoreboard
      logic [1:0]        vld, rdy, rv, rr, res, exp_g;
      logic [DATA_W-1:0] a [2];
      logic [DATA_W-1:0] b [2];
      logic [2:0]        op [2];
      logic              front;
      int                qsz;
      bit                pref, ev;
      xfer_cnt  = '{0, 0};
      drain_cnt = '{0, 0};
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            exp_q0.delete();
            exp_q1.delete();
            busy[0] = 1'b0;
            busy[1] = 1'b0;
            last_gnt = 1'b1;
         end else begin
            vld   = {bus.req1_vld_w_i_h, bus.req0_vld_w_i_h};
            rdy   = {bus.req1_rdy_w_o_h, bus.req0_rdy_w_o_h};
            rv    = {bus.rsp1_vld_w_o_h, bus.rsp0_vld_w_o_h};
            rr    = {bus.rsp1_rdy_w_i_h, bus.rsp0_rdy_w_i_h};
            res   = {bus.rsp1_res_w_o_h, bus.rsp0_res_w_o_h};
            a[0]  = bus.req0_a_w_i;  a[1]  = bus.req1_a_w_i;
            b[0]  = bus.req0_b_w_i;  b[1]  = bus.req1_b_w_i;
            op[0] = bus.req0_op_w_i; op[1] = bus.req1_op_w_i;

            // Expected grant from the arbitration rules
            exp_g = 2'b00;
            if (vld[0] && !busy[0] && vld[1] && !busy[1]) begin
               pref = RR_EN ? !last_gnt : 1'b0;
               exp_g[pref] = 1'b1;
            end else if (vld[0] && !busy[0]) begin
               exp_g = 2'b01;
            end else if (vld[1] && !busy[1]) begin
               exp_g = 2'b10;
            end
            checks++;
            if (rdy !== exp_g) begin
               errors++;
               $display("FAIL grant: cyc=%0d rdy=%b expected=%b", cyc, rdy, exp_g);
            end
            checks++;
            if (rdy === 2'b11) begin
               errors++;
               $display("FAIL both_rdy: cyc=%0d rdy=%b expected one-hot", cyc, rdy);
            end

            for (int i = 0; i < 2; i++) begin
               ev = busy[i] && (cyc >= t_n[i] + 1);
               checks++;
               if (rv[i] !== ev) begin
                  errors++;
                  $display("FAIL rsp_vld%0d: cyc=%0d got=%b expected=%b", i, cyc, rv[i], ev);
               end
               if (rv[i] === 1'b1) begin
                  qsz   = (i == 0) ? exp_q0.size() : exp_q1.size();
                  front = 1'bx;
                  if (qsz > 0) front = (i == 0) ? exp_q0[0] : exp_q1[0];
                  checks++;
                  if (qsz == 0 || res[i] !== front) begin
                     errors++;
                     $display("FAIL rsp_res%0d: cyc=%0d got=%b expected=%b (queued=%0d)",
                              i, cyc, res[i], front, qsz);
                  end
               end
               checks++;
               if (rdy[i] === 1'b1 && rv[i] === 1'b1) begin
                  errors++;
                  $display("FAIL stage_drain_overlap%0d: cyc=%0d grant while response pending", i, cyc);
               end
            end

            // Advance the model to the next cycle
            for (int i = 0; i < 2; i++) begin
               if (rv[i] === 1'b1 && rr[i] === 1'b1) begin
                  if (i == 0 && exp_q0.size() > 0) void'(exp_q0.pop_front());
                  if (i == 1 && exp_q1.size() > 0) void'(exp_q1.pop_front());
                  busy[i] = 1'b0;
                  drain_cnt[i]++;
               end
            end
            for (int i = 0; i < 2; i++) begin
               if (rdy[i] === 1'b1 && vld[i] === 1'b1) begin
                  if (i == 0) exp_q0.push_back(ref_res(a[i], b[i], op[i]));
                  else        exp_q1.push_back(ref_res(a[i], b[i], op[i]));
                  busy[i]  = 1'b1;
                  t_n[i]   = cyc + 1;
                  last_gnt = (i == 1);
                  xfer_cnt[i]++;
               end
            end
         end
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      set_req(0, 1'b1, 32'h1234, 32'h1234, 3'b000);
      set_req(1, 1'b1, 32'h5, 32'h6, 3'b110);
      bus.rsp0_rdy_w_i_h = 1'b1;
      bus.rsp1_rdy_w_i_h = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.req0_rdy_w_o_h, bus.req1_rdy_w_o_h} !== 2'b00) begin
         errors++;
         $display("FAIL reset_rdy: got=%b%b expected=00", bus.req0_rdy_w_o_h, bus.req1_rdy_w_o_h);
      end
      checks++;
      if ({bus.rsp0_vld_w_o_h, bus.rsp1_vld_w_o_h, bus.rsp0_res_w_o_h, bus.rsp1_res_w_o_h} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_rsp: vld=%b%b res=%b%b expected all 0", bus.rsp0_vld_w_o_h,
                  bus.rsp1_vld_w_o_h, bus.rsp0_res_w_o_h, bus.rsp1_res_w_o_h);
      end
      checks++;
      if (bus.cmp_a_w_o !== '0 || bus.cmp_b_w_o !== '0) begin
         errors++;
         $display("FAIL reset_cmp: a=%h b=%h expected 0", bus.cmp_a_w_o, bus.cmp_b_w_o);
      end
      set_req(0, 1'b0, '0, '0, 3'b000);
      set_req(1, 1'b0, '0, '0, 3'b000);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_contention();
      int prev_id = -1;
      int id;
      int ngr = 0;
      bus.rsp0_rdy_w_i_h = 1'b1;
      bus.rsp1_rdy_w_i_h = 1'b1;
      for (int k = 0; k < 30; k++) begin
         random_req(0, 1'b1);
         random_req(1, 1'b1);
         #1;
         checks++;
         if (bus.req0_rdy_w_o_h === 1'b1 && bus.req1_rdy_w_o_h === 1'b1) begin
            errors++;
            $display("FAIL contention_both_rdy: k=%0d", k);
         end
         if (bus.req0_rdy_w_o_h === 1'b1 || bus.req1_rdy_w_o_h === 1'b1) begin
            id = (bus.req1_rdy_w_o_h === 1'b1) ? 1 : 0;
            checks++;
            if ((prev_id < 0 && id != 0) || (prev_id >= 0 && id == prev_id)) begin
               errors++;
               $display("FAIL contention_order: k=%0d granted=%0d previous=%0d expected alternation from req0",
                        k, id, prev_id);
            end
            prev_id = id;
            ngr++;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (ngr < 18) begin
         errors++;
         $display("FAIL contention_count: grants=%0d expected>=18", ngr);
      end
      idle(6);
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         errors++;
         $display("FAIL contention_drain: left=%0d/%0d expected 0/0", exp_q0.size(), exp_q1.size());
      end
   endtask

   task automatic test_single();
      logic [2:0] ops [2];
      logic       exp [2];
      ops[0] = 3'b000; exp[0] = 1'b1;
      ops[1] = 3'b001; exp[1] = 1'b0;
      bus.rsp0_rdy_w_i_h = 1'b1;
      for (int t = 0; t < 2; t++) begin
         set_req(0, 1'b1, 32'd5, 32'd5, ops[t]);
         #1;
         checks++;
         if (bus.req0_rdy_w_o_h !== 1'b1) begin
            errors++;
            $display("FAIL single_rdy%0d: got=%b expected=1", t, bus.req0_rdy_w_o_h);
         end
         @(posedge clk);
         #1;
         set_req(0, 1'b0, 32'd5, 32'd5, ops[t]);
         checks++;
         if (bus.rsp0_vld_w_o_h !== 1'b0) begin
            errors++;
            $display("FAIL single_early%0d: rsp0_vld=%b expected=0", t, bus.rsp0_vld_w_o_h);
         end
         @(posedge clk);
         #1;
         checks++;
         if (bus.rsp0_vld_w_o_h !== 1'b1 || bus.rsp0_res_w_o_h !== exp[t]) begin
            errors++;
            $display("FAIL single_rsp%0d: vld=%b res=%b expected vld=1 res=%b", t,
                     bus.rsp0_vld_w_o_h, bus.rsp0_res_w_o_h, exp[t]);
         end
         @(posedge clk);
         #1;
         checks++;
         if (bus.rsp0_vld_w_o_h !== 1'b0) begin
            errors++;
            $display("FAIL single_drain%0d: rsp0_vld=%b expected=0", t, bus.rsp0_vld_w_o_h);
         end
      end
      idle(2);
   endtask

   task automatic test_signed_unsigned();
      logic [2:0] ops [4];
      logic       exp [4];
      logic       res;
      bit         ok;
      ops[0] = 3'b100; exp[0] = 1'b1;
      ops[1] = 3'b110; exp[1] = 1'b0;
      ops[2] = 3'b111; exp[2] = 1'b1;
      ops[3] = 3'b101; exp[3] = 1'b0;
      for (int t = 0; t < 4; t++) begin
         drive_req(0, 32'hFFFF_FFFF, 32'h0000_0001, ops[t], ok);
         wait_rsp(0, res, ok);
         checks++;
         if (!ok || res !== exp[t]) begin
            errors++;
            $display("FAIL signed_unsigned op=%b: got=%b (seen=%0d) expected=%b", ops[t], res, ok, exp[t]);
         end
      end
      idle(2);
   endtask

   task automatic test_backpressure();
      int   n0 = 0;
      int   n1 = 0;
      bit   seen = 1'b0;
      logic held = 1'b0;
      bus.rsp0_rdy_w_i_h = 1'b1;
      bus.rsp1_rdy_w_i_h = 1'b0;
      set_req(1, 1'b1, 32'h10, 32'h20, 3'b110);
      for (int k = 0; k < 20; k++) begin
         random_req(0, 1'b1);
         #1;
         if (bus.req1_rdy_w_o_h === 1'b1) n1++;
         if (bus.req0_rdy_w_o_h === 1'b1) n0++;
         if (bus.rsp1_vld_w_o_h === 1'b1) begin
            if (!seen) begin
               seen = 1'b1;
               held = bus.rsp1_res_w_o_h;
            end else begin
               checks++;
               if (bus.rsp1_res_w_o_h !== held) begin
                  errors++;
                  $display("FAIL bp_stable: k=%0d rsp1_res=%b expected=%b", k, bus.rsp1_res_w_o_h, held);
               end
            end
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (n1 != 1) begin
         errors++;
         $display("FAIL bp_req1_count: transfers=%0d expected=1", n1);
      end
      checks++;
      if (!seen || held !== 1'b1) begin
         errors++;
         $display("FAIL bp_rsp1: seen=%0d res=%b expected res=1", seen, held);
      end
      checks++;
      if (n0 < 6) begin
         errors++;
         $display("FAIL bp_req0_served: transfers=%0d expected>=6", n0);
      end
      set_req(0, 1'b0, '0, '0, 3'b000);
      bus.rsp1_rdy_w_i_h = 1'b1;
      #1;
      checks++;
      if (bus.req1_rdy_w_o_h !== 1'b0) begin
         errors++;
         $display("FAIL bp_no_bypass: rdy1=%b expected=0", bus.req1_rdy_w_o_h);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.req1_rdy_w_o_h !== 1'b1) begin
         errors++;
         $display("FAIL bp_regrant: rdy1=%b expected=1", bus.req1_rdy_w_o_h);
      end
      @(posedge clk);
      #1;
      idle(5);
   endtask

   task automatic test_reset_mid();
      bit ok;
      bus.rsp0_rdy_w_i_h = 1'b1;
      bus.rsp1_rdy_w_i_h = 1'b1;
      drive_req(0, 32'h7, 32'h7, 3'b000, ok);
      #1;
      rst = 1'b1;
      set_req(0, 1'b1, 32'h3, 32'h3, 3'b000);
      set_req(1, 1'b1, 32'h3, 32'h4, 3'b011);
      #1;
      checks++;
      if ({bus.req0_rdy_w_o_h, bus.req1_rdy_w_o_h, bus.rsp0_vld_w_o_h, bus.rsp1_vld_w_o_h,
           bus.rsp0_res_w_o_h, bus.rsp1_res_w_o_h} !== 6'b000000) begin
         errors++;
         $display("FAIL mid_reset_outputs: rdy=%b%b vld=%b%b res=%b%b expected all 0",
                  bus.req0_rdy_w_o_h, bus.req1_rdy_w_o_h, bus.rsp0_vld_w_o_h, bus.rsp1_vld_w_o_h,
                  bus.rsp0_res_w_o_h, bus.rsp1_res_w_o_h);
      end
      checks++;
      if (bus.cmp_a_w_o !== '0 || bus.cmp_b_w_o !== '0) begin
         errors++;
         $display("FAIL mid_reset_cmp: a=%h b=%h expected 0", bus.cmp_a_w_o, bus.cmp_b_w_o);
      end
      set_req(0, 1'b0, '0, '0, 3'b000);
      set_req(1, 1'b0, '0, '0, 3'b000);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.rsp0_vld_w_o_h !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ghost: k=%0d rsp0_vld=%b expected=0", k, bus.rsp0_vld_w_o_h);
         end
      end
      set_req(0, 1'b1, 32'h9, 32'h2, 3'b101);
      set_req(1, 1'b1, 32'h2, 32'h9, 3'b100);
      #1;
      checks++;
      if (bus.req0_rdy_w_o_h !== 1'b1 || bus.req1_rdy_w_o_h !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_first_grant: rdy0=%b rdy1=%b expected 1/0",
                  bus.req0_rdy_w_o_h, bus.req1_rdy_w_o_h);
      end
      @(posedge clk);
      #1;
      idle(6);
   endtask

   task automatic test_random();
      int start;
      int done;
      start = drain_cnt[0] + drain_cnt[1];
      done  = 0;
      for (int k = 0; k < 30000 && done < 10000; k++) begin
         random_req(0, $urandom_range(0, 7) != 0);
         random_req(1, $urandom_range(0, 7) != 0);
         bus.rsp0_rdy_w_i_h = ($urandom_range(0, 7) != 0);
         bus.rsp1_rdy_w_i_h = ($urandom_range(0, 7) != 0);
         @(posedge clk);
         #1;
         done = drain_cnt[0] + drain_cnt[1] - start;
      end
      idle(6);
      done = drain_cnt[0] + drain_cnt[1] - start;
      checks++;
      if (done < 10000) begin
         errors++;
         $display("FAIL random_volume: responses=%0d expected>=10000", done);
      end
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         errors++;
         $display("FAIL random_drain: left=%0d/%0d expected 0/0", exp_q0.size(), exp_q1.size());
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      set_req(0, 1'b0, '0, '0, 3'b000);
      set_req(1, 1'b0, '0, '0, 3'b000);
      bus.rsp0_rdy_w_i_h = 1'b1;
      bus.rsp1_rdy_w_i_h = 1'b1;
      test_reset();
      test_contention();
      test_single();
      test_signed_unsigned();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
